// File: rtl/alu_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pipe
//
// Upstream stage of the ALU result multiplexer. Each accepted op (ALUOp + funct)
// is decoded into a 4-bit ALU result selector and carried together with a
// destination tag through a registered 2-entry skid buffer (head + skid) with a
// valid/ready handshake on both sides.
//
// Selector codes: AND=0000 OR=0001 ADD=0010 SUB=0110 SLT=0111 NOR=1100.
//
// Build option:
//   ALU_CTRL_ILLEGAL_TRAP_EN  defined: an undefined R-type funct decodes to
//                             selector 0000 with out_illegal=1 for that entry,
//                             and sets err_sticky when the op is accepted.
//                             undefined: an undefined funct decodes to ADD (0010);
//                             out_illegal and err_sticky stay 0.
//
// Ports:
//   clock        in   1      single clock, rising edge
//   reset_n      in   1      asynchronous active-low reset
//   flush        in   1      synchronous clear of all buffered entries
//   in_valid     in   1      upstream offers an op
//   in_ready     out  1      stage can accept (registered, state != TWO)
//   in_aluop     in   2      00 ld/st, 01 branch, 10 R-type, 11 immediate-OR
//   in_funct     in   6      R-type funct (used only when in_aluop == 10)
//   in_tag       in   TAG_W  destination tag, passed through unchanged
//   out_valid    out  1      out_* hold a decoded op (registered, state != EMPTY)
//   out_ready    in   1      downstream consumes the head op
//   out_seletor  out  4      ALU result selector of the head op
//   out_tag      out  TAG_W  tag of the head op
//   out_illegal  out  1      head op had an undefined funct (trap build only)
//   err_sticky   out  1      set by the first accepted illegal op; reset only
// -----------------------------------------------------------------------------
module alu_ctrl_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_aluop,
    input  logic [5:0]       in_funct,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_seletor,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             err_sticky
);

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [3:0]         head_sel_reg;
    logic [TAG_W-1:0]   head_tag_reg;
    logic               head_ill_reg;
    logic [3:0]         skid_sel_reg;
    logic [TAG_W-1:0]   skid_tag_reg;
    logic               skid_ill_reg;
    logic               err_sticky_reg;

    logic [3:0]         dec_sel;
    logic               dec_illegal;
    logic [3:0]         rtype_sel;
    logic               rtype_undef;
    logic               accept;
    logic               pop;

    // R-type funct table; rtype_undef flags any funct not in the table.
    always_comb begin
        rtype_sel   = SEL_ADD;
        rtype_undef = 1'b0;
        case (in_funct)
            6'b100000: rtype_sel = SEL_ADD;
            6'b100010: rtype_sel = SEL_SUB;
            6'b100100: rtype_sel = SEL_AND;
            6'b100101: rtype_sel = SEL_OR;
            6'b101010: rtype_sel = SEL_SLT;
            6'b100111: rtype_sel = SEL_NOR;
            default:   rtype_undef = 1'b1;
        endcase
    end

    always_comb begin
        dec_sel     = SEL_ADD;
        dec_illegal = 1'b0;
        case (in_aluop)
            2'b00: dec_sel = SEL_ADD;
            2'b01: dec_sel = SEL_SUB;
            2'b11: dec_sel = SEL_OR;
            default: begin
                if (rtype_undef) begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                    dec_sel     = SEL_AND;
                    dec_illegal = 1'b1;
`else
                    // Undefined funct falls back to ADD; no trap indication.
                    dec_sel     = SEL_ADD;
                    dec_illegal = 1'b0;
`endif
                end else begin
                    dec_sel = rtype_sel;
                end
            end
        endcase
    end

    // in_ready/out_valid are registered copies of the state, so neither
    // handshake output has a combinational path from the opposite side.
    assign accept = in_valid & in_ready_reg;
    assign pop    = out_valid_reg & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= EMPTY;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
            head_sel_reg   <= 4'b0000;
            head_tag_reg   <= '0;
            head_ill_reg   <= 1'b0;
            skid_sel_reg   <= 4'b0000;
            skid_tag_reg   <= '0;
            skid_ill_reg   <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else if (flush) begin
            // Same-cycle input is dropped and same-cycle pop is void; head
            // payload keeps its last value so out_* stay don't-care-free.
            state_reg     <= EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            if (accept && dec_illegal) begin
                err_sticky_reg <= 1'b1;
            end
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        head_sel_reg  <= dec_sel;
                        head_tag_reg  <= in_tag;
                        head_ill_reg  <= dec_illegal;
                        state_reg     <= ONE;
                        out_valid_reg <= 1'b1;
                        in_ready_reg  <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        skid_sel_reg <= dec_sel;
                        skid_tag_reg <= in_tag;
                        skid_ill_reg <= dec_illegal;
                        state_reg    <= TWO;
                        in_ready_reg <= 1'b0;
                    end else if (pop && !accept) begin
                        state_reg     <= EMPTY;
                        out_valid_reg <= 1'b0;
                    end else if (pop && accept) begin
                        // Head leaves and the new op takes its place.
                        head_sel_reg <= dec_sel;
                        head_tag_reg <= in_tag;
                        head_ill_reg <= dec_illegal;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_sel_reg <= skid_sel_reg;
                        head_tag_reg <= skid_tag_reg;
                        head_ill_reg <= skid_ill_reg;
                        state_reg    <= ONE;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign out_seletor = head_sel_reg;
    assign out_tag     = head_tag_reg;
    assign out_illegal = head_ill_reg;
    assign err_sticky  = err_sticky_reg;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_pipe
//
// Scoreboard bench for alu_ctrl_pipe. The stimulus process drives directed
// scenarios followed by a randomized stream. A collector/monitor process on the
// falling edge keeps a FIFO model of buffered ops: it checks handshake outputs
// against the model occupancy, compares the head against the queue front, and
// then applies this cycle's pop/accept/flush to the model.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_pipe;

    localparam int TAG_W = 5;

    typedef struct {
        logic [3:0]       sel;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } entry_t;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_aluop;
    logic [5:0]       in_funct;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_seletor;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic             err_sticky;

    int n_cmp = 0;
    int n_bad = 0;

    entry_t           exp_q[$];
    logic             exp_sticky;
    logic [3:0]       last_sel;
    logic [TAG_W-1:0] last_tag;
    logic             last_ill;

    alu_ctrl_pipe #(.TAG_W(TAG_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_aluop    (in_aluop),
        .in_funct    (in_funct),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_seletor (out_seletor),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .err_sticky  (err_sticky)
    );

    always #5 clock = ~clock;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Reference decode straight from the opcode table.
    function automatic entry_t ref_decode(input logic [1:0] op, input logic [5:0] f,
                                          input logic [TAG_W-1:0] tag);
        entry_t e;
        e.tag = tag;
        e.ill = 1'b0;
        e.sel = 4'b0010;
        if (op == 2'b00)      e.sel = 4'b0010;
        else if (op == 2'b01) e.sel = 4'b0110;
        else if (op == 2'b11) e.sel = 4'b0001;
        else begin
            if (f == 6'b100000)      e.sel = 4'b0010;
            else if (f == 6'b100010) e.sel = 4'b0110;
            else if (f == 6'b100100) e.sel = 4'b0000;
            else if (f == 6'b100101) e.sel = 4'b0001;
            else if (f == 6'b101010) e.sel = 4'b0111;
            else if (f == 6'b100111) e.sel = 4'b1100;
            else if (TRAP) begin
                e.sel = 4'b0000;
                e.ill = 1'b1;
            end else begin
                e.sel = 4'b0010;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Collector + monitor: check DUT against model state, then advance model.
    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_sel", int'(out_seletor), 0);
            chk("rst_tag", int'(out_tag), 0);
            chk("rst_illegal", int'(out_illegal), 0);
            chk("rst_sticky", int'(err_sticky), 0);
            exp_q.delete();
            exp_sticky = 1'b0;
            last_sel   = 4'b0000;
            last_tag   = '0;
            last_ill   = 1'b0;
        end else begin
            int  occ;
            bit  acc;
            occ = exp_q.size();
            chk("in_ready", int'(in_ready), (occ < 2) ? 1 : 0);
            chk("out_valid", int'(out_valid), (occ > 0) ? 1 : 0);
            chk("err_sticky", int'(err_sticky), int'(exp_sticky));
            if (occ > 0) begin
                chk("head_sel", int'(out_seletor), int'(exp_q[0].sel));
                chk("head_tag", int'(out_tag), int'(exp_q[0].tag));
                chk("head_illegal", int'(out_illegal), int'(exp_q[0].ill));
                last_sel = exp_q[0].sel;
                last_tag = exp_q[0].tag;
                last_ill = exp_q[0].ill;
            end else begin
                chk("hold_sel", int'(out_seletor), int'(last_sel));
                chk("hold_tag", int'(out_tag), int'(last_tag));
                chk("hold_illegal", int'(out_illegal), int'(last_ill));
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                acc = in_valid && (occ < 2);
                if (out_ready && occ > 0) begin
                    $display("pop  tag=%0d sel=%b ill=%0d", exp_q[0].tag, exp_q[0].sel,
                             exp_q[0].ill);
                    void'(exp_q.pop_front());
                end
                if (acc) begin
                    entry_t e;
                    e = ref_decode(in_aluop, in_funct, in_tag);
                    exp_q.push_back(e);
                    if (e.ill) exp_sticky = 1'b1;
                    $display("push tag=%0d aluop=%b funct=%b exp_sel=%b", in_tag, in_aluop,
                             in_funct, e.sel);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [TAG_W-1:0] tag);
        in_valid = v;
        in_aluop = op;
        in_funct = f;
        in_tag   = tag;
    endtask

    logic [5:0] legal_funct [6];

    initial begin
        legal_funct[0] = 6'b100100;
        legal_funct[1] = 6'b100101;
        legal_funct[2] = 6'b100000;
        legal_funct[3] = 6'b100010;
        legal_funct[4] = 6'b101010;
        legal_funct[5] = 6'b100111;

        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 6'd0, '0);
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Full R-type stream, downstream always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'b10, legal_funct[i], TAG_W'(i + 1));
            step();
        end
        drive(1'b0, 2'b00, 6'd0, '0);
        repeat (3) step();

        // Backpressure: fill both entries, then drain.
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 6'b100000, 5'd3);
        step();
        drive(1'b1, 2'b10, 6'b100010, 5'd4);
        step();
        drive(1'b0, 2'b00, 6'd0, '0);
        repeat (2) step();
        out_ready = 1'b1;
        repeat (3) step();

        // Non-R-type ops ignore funct.
        drive(1'b1, 2'b00, 6'b111111, 5'd10);
        step();
        drive(1'b1, 2'b01, 6'b111111, 5'd11);
        step();
        drive(1'b1, 2'b11, 6'b111111, 5'd12);
        step();
        drive(1'b0, 2'b00, 6'd0, '0);
        repeat (2) step();

        // Undefined funct, then flush: sticky (trap build) must survive flush.
        drive(1'b1, 2'b10, 6'b000000, 5'd9);
        step();
        drive(1'b0, 2'b00, 6'd0, '0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (2) step();

        // Flush while TWO with simultaneous input and pop.
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 6'd0, 5'd20);
        step();
        drive(1'b1, 2'b00, 6'd0, 5'd21);
        step();
        drive(1'b1, 2'b01, 6'd0, 5'd22);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 2'b00, 6'd0, '0);
        repeat (3) step();

        // Reset mid-stream with two entries buffered, then one op after release.
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 6'b100101, 5'd5);
        step();
        drive(1'b1, 2'b10, 6'b000001, 5'd6);
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        drive(1'b1, 2'b10, 6'b101010, 5'd7);
        step();
        drive(1'b0, 2'b00, 6'd0, '0);
        out_ready = 1'b1;
        repeat (3) step();

        // Randomized stream.
        for (int i = 0; i < 600; i++) begin
            logic [5:0] f;
            if ($urandom_range(1, 0) == 1) f = legal_funct[$urandom_range(5, 0)];
            else                          f = 6'($urandom);
            drive(1'($urandom_range(3, 0) != 0), 2'($urandom), f, TAG_W'($urandom));
            out_ready = 1'($urandom_range(3, 0) != 0);
            flush     = 1'($urandom_range(19, 0) == 0);
            step();
        end
        flush = 1'b0;
        drive(1'b0, 2'b00, 6'd0, '0);
        out_ready = 1'b1;
        repeat (10) step();
        chk("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
